// File: rtl/reflet_prog_mem_pkg.sv
// rtl/reflet_prog_mem_pkg.sv - shared state encoding and word-size legality check for Reflet memories
package reflet_prog_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_FULL  = 2'd3
   } mem_state_t;

   localparam int BYTE_W        = 8;
   localparam int MIN_WORD_SIZE = 8;
   localparam int MAX_WORD_SIZE = 64;

   function automatic bit word_size_ok(input int ws);
      return (ws >= MIN_WORD_SIZE) && (ws <= MAX_WORD_SIZE) && ((ws % BYTE_W) == 0);
   endfunction

endpackage

// File: rtl/reflet_prog_mem_if.sv
// rtl/reflet_prog_mem_if.sv - CPU access port and byte-serial loader port of the program memory
interface reflet_prog_mem_if #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 4
) ();

   logic [ADDR_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] data_in;
   logic                 write_en;
   logic                 enable;
   logic [WORD_SIZE-1:0] data_out;
   logic                 ready;

   logic                 load_start;
   logic                 load_end;
   logic                 load_valid;
   logic [7:0]           load_data;
   logic                 load_ready;
   logic                 load_busy;
   logic                 load_overflow;
   logic [ADDR_SIZE:0]   load_words;

   modport master (
      output addr, data_in, write_en, enable,
      output load_start, load_end, load_valid, load_data,
      input  data_out, ready,
      input  load_ready, load_busy, load_overflow, load_words
   );

   modport slave (
      input  addr, data_in, write_en, enable,
      input  load_start, load_end, load_valid, load_data,
      output data_out, ready,
      output load_ready, load_busy, load_overflow, load_words
   );

endinterface

// File: rtl/reflet_byte_packer.sv
// rtl/reflet_byte_packer.sv - little-endian byte-to-word assembly with zero-padded partial flush
module reflet_byte_packer
   import reflet_prog_mem_pkg::*;
#(
   parameter int BYTES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    flush,
   input  logic                    byte_valid,
   input  logic [BYTE_W-1:0]       byte_data,
   output logic [BYTES*BYTE_W-1:0] word_data,
   output logic                    word_valid,
   output logic                    partial
);

   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

   logic [IDX_W-1:0]        idx;
   logic [BYTES*BYTE_W-1:0] acc;

   // word_data already contains this cycle's byte so a completing word is written without a bubble
   always_comb begin
      word_data = acc;
      for (int i = 0; i < BYTES; i++) begin
         if (byte_valid && (idx == IDX_W'(i))) begin
            word_data[i*BYTE_W +: BYTE_W] = byte_data;
         end
      end
   end

   assign word_valid = byte_valid && (idx == LAST);
   assign partial    = byte_valid ? (idx != LAST) : (idx != '0);

   // acc is cleared after every word so unwritten upper lanes read as zero on flush
   always_ff @(posedge clk) begin
      if (reset || clear || flush || word_valid) begin
         idx <= '0;
         acc <= '0;
      end else if (byte_valid) begin
         idx <= idx + 1'b1;
         acc <= word_data;
      end
   end

endmodule

// File: rtl/reflet_prog_mem.sv
// rtl/reflet_prog_mem.sv - run-time loadable program RAM with a stalled 1-cycle-latency CPU port
module reflet_prog_mem
   import reflet_prog_mem_pkg::*;
#(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 4
) (
   input logic              clk,
   input logic              reset,
   reflet_prog_mem_if.slave bus
);

   localparam int BYTES = WORD_SIZE / 8;
   localparam int DEPTH = 2 ** ADDR_SIZE;
   localparam logic [ADDR_SIZE:0]   WORDS_MAX = {1'b1, {ADDR_SIZE{1'b0}}};
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

   if (!word_size_ok(WORD_SIZE)) begin : g_bad_word_size
      $error("reflet_prog_mem: WORD_SIZE must be a multiple of 8 in 8..64");
   end

   mem_state_t state, state_nxt;

   logic [WORD_SIZE-1:0] mem [DEPTH];
   logic [WORD_SIZE-1:0] data_out_q;
   logic [ADDR_SIZE:0]   load_words_q;
   logic                 overflow_q;
   logic [ADDR_SIZE-1:0] ptr;

   logic                 start_load;
   logic                 pk_valid;
   logic                 pk_flush;
   logic [WORD_SIZE-1:0] pk_word;
   logic                 pk_word_valid;
   logic                 pk_partial;
   logic                 loader_wr;

   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;

   // The loader never wraps: word DEPTH-1 moves to FULL, so the word count doubles as the write pointer
   assign ptr        = load_words_q[ADDR_SIZE-1:0];
   assign start_load = (state == ST_IDLE) && bus.load_start;
   assign pk_valid   = (state == ST_LOAD) && bus.load_valid;
   assign pk_flush   = (state == ST_FLUSH);
   assign loader_wr  = pk_word_valid || pk_flush;

   reflet_byte_packer #(.BYTES(BYTES)) u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (start_load),
      .flush      (pk_flush),
      .byte_valid (pk_valid),
      .byte_data  (bus.load_data),
      .word_data  (pk_word),
      .word_valid (pk_word_valid),
      .partial    (pk_partial)
   );

   always_comb begin
      state_nxt      = state;
      bus.ready      = 1'b0;
      bus.load_ready = 1'b0;
      bus.load_busy  = 1'b1;
      case (state)
         ST_IDLE: begin
            bus.ready     = 1'b1;
            bus.load_busy = 1'b0;
            if (bus.load_start) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            bus.load_ready = 1'b1;
            if (bus.load_end) begin
               state_nxt = pk_partial ? ST_FLUSH : ST_IDLE;
            end else if (pk_word_valid && (ptr == LAST_ADDR)) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FLUSH: state_nxt = ST_IDLE;
         ST_FULL: begin
            if (bus.load_end) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr;
      mem_wdata = pk_word;
      if ((state == ST_IDLE) && bus.enable && bus.write_en) begin
         mem_we    = 1'b1;
         mem_waddr = bus.addr;
         mem_wdata = bus.data_in;
      end else if (loader_wr) begin
         mem_we = 1'b1;
      end
   end

   // Array has no reset so a mid-load reset keeps the words already loaded
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         data_out_q   <= '0;
         load_words_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == ST_IDLE) && bus.enable && !bus.write_en) begin
            data_out_q <= mem[bus.addr];
         end
         if (start_load) begin
            load_words_q <= '0;
         end else if (loader_wr && (load_words_q != WORDS_MAX)) begin
            load_words_q <= load_words_q + 1'b1;
         end
         if (start_load) begin
            overflow_q <= 1'b0;
         end else if ((state == ST_FULL) && bus.load_valid) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bus.data_out      = data_out_q;
   assign bus.load_words    = load_words_q;
   assign bus.load_overflow = overflow_q;

endmodule

// File: tb/tb_reflet_prog_mem.sv
// tb/tb_reflet_prog_mem.sv - self-checking bench for reflet_prog_mem (16-bit and 8-bit words)
module tb_reflet_prog_mem;

   typedef logic [7:0] bq_t [$];

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reflet_prog_mem_if #(.WORD_SIZE(16), .ADDR_SIZE(4)) m16 ();
   reflet_prog_mem_if #(.WORD_SIZE(8),  .ADDR_SIZE(4)) m8 ();

   reflet_prog_mem #(.WORD_SIZE(16), .ADDR_SIZE(4)) u_dut16 (.clk(clk), .reset(reset), .bus(m16));
   reflet_prog_mem #(.WORD_SIZE(8),  .ADDR_SIZE(4)) u_dut8  (.clk(clk), .reset(reset), .bus(m8));

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] mdl16 [16];
   logic [7:0]  mdl8  [16];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      m16.addr = '0; m16.data_in = '0; m16.write_en = 0; m16.enable = 0;
      m16.load_start = 0; m16.load_end = 0; m16.load_valid = 0; m16.load_data = '0;
      m8.addr = '0; m8.data_in = '0; m8.write_en = 0; m8.enable = 0;
      m8.load_start = 0; m8.load_end = 0; m8.load_valid = 0; m8.load_data = '0;
   endtask

   task automatic wr16(input logic [3:0] a, input logic [15:0] d);
      m16.addr = a; m16.data_in = d; m16.enable = 1; m16.write_en = 1;
      tick;
      m16.enable = 0; m16.write_en = 0;
   endtask

   task automatic rd16(input logic [3:0] a, output logic [15:0] d);
      m16.addr = a; m16.enable = 1; m16.write_en = 0;
      tick;
      d = m16.data_out;
      m16.enable = 0;
   endtask

   task automatic wr8(input logic [3:0] a, input logic [7:0] d);
      m8.addr = a; m8.data_in = d; m8.enable = 1; m8.write_en = 1;
      tick;
      m8.enable = 0; m8.write_en = 0;
   endtask

   task automatic rd8(input logic [3:0] a, output logic [7:0] d);
      m8.addr = a; m8.enable = 1; m8.write_en = 0;
      tick;
      d = m8.data_out;
      m8.enable = 0;
   endtask

   task automatic start16;
      m16.load_start = 1; tick; m16.load_start = 0;
   endtask

   task automatic end16;
      m16.load_end = 1; tick; m16.load_end = 0;
   endtask

   task automatic byte16(input logic [7:0] b);
      m16.load_valid = 1; m16.load_data = b; tick; m16.load_valid = 0;
   endtask

   // Reference: byte k of a load lands in word k/2, lane k%2; a trailing odd byte has a zero upper lane
   task automatic model_load16(input bq_t q);
      for (int k = 0; k < q.size() && k < 32; k++) begin
         if (k % 2 == 0) mdl16[k/2] = {8'h00, q[k]};
         else            mdl16[k/2][15:8] = q[k];
      end
   endtask

   task automatic test_reset;
      reset = 1; tick; tick; reset = 0;
      n_cmp++; if (m16.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", m16.ready); end
      n_cmp++; if (m16.data_out !== 16'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0000", m16.data_out); end
      n_cmp++; if (m16.load_words !== 5'd0) begin n_err++; $display("FAIL reset_load_words: got %0d want 0", m16.load_words); end
      n_cmp++; if (m16.load_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", m16.load_overflow); end
      n_cmp++; if (m16.load_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", m16.load_busy); end
      n_cmp++; if (m16.load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready: got %b want 0", m16.load_ready); end
      n_cmp++; if (m8.data_out !== 8'h0) begin n_err++; $display("FAIL reset_data_out8: got %h want 00", m8.data_out); end
   endtask

   task automatic test_cpu_rw;
      logic [15:0] d;
      logic [7:0]  d8;
      logic [3:0]  a;
      for (int i = 0; i < 16; i++) begin
         d = 16'($urandom); wr16(4'(i), d); mdl16[i] = d;
         d8 = 8'($urandom); wr8(4'(i), d8); mdl8[i] = d8;
      end
      n_cmp++; if (m16.data_out !== 16'h0) begin n_err++; $display("FAIL write_holds_data_out: got %h want 0000", m16.data_out); end
      for (int i = 0; i < 12; i++) begin
         a = 4'($urandom_range(0, 15));
         rd16(a, d);
         n_cmp++; if (d !== mdl16[a]) begin n_err++; $display("FAIL cpu_read[%0d]: got %h want %h", a, d, mdl16[a]); end
      end
      n_cmp++; if (m16.data_out !== mdl16[a]) begin n_err++; $display("FAIL idle_holds_data_out: got %h want %h", m16.data_out, mdl16[a]); end
   endtask

   task automatic test_basic_load;
      bq_t q;
      logic [15:0] d;
      q = '{8'h41, 8'h53, 8'h52, 8'h4D};
      start16;
      n_cmp++; if ({m16.ready, m16.load_ready, m16.load_busy} !== 3'b011) begin n_err++; $display("FAIL basic_load_flags: got %b want 011", {m16.ready, m16.load_ready, m16.load_busy}); end
      foreach (q[i]) byte16(q[i]);
      end16;
      n_cmp++; if (m16.ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_after_end: got %b want 1", m16.ready); end
      n_cmp++; if (m16.load_words !== 5'd2) begin n_err++; $display("FAIL basic_load_words: got %0d want 2", m16.load_words); end
      model_load16(q);
      m16.addr = 4'd1; m16.enable = 1; m16.write_en = 0;
      tick;
      m16.enable = 0;
      n_cmp++; if (m16.data_out !== 16'h4D52) begin n_err++; $display("FAIL basic_read1: got %h want 4d52", m16.data_out); end
      rd16(4'd0, d);
      n_cmp++; if (d !== 16'h5341) begin n_err++; $display("FAIL basic_read0: got %h want 5341", d); end
   endtask

   task automatic test_partial_flush;
      bq_t q;
      logic [15:0] d;
      q = '{8'h11, 8'h22, 8'h33};
      start16;
      foreach (q[i]) byte16(q[i]);
      m16.load_end = 1; tick; m16.load_end = 0;
      n_cmp++; if ({m16.ready, m16.load_ready, m16.load_busy} !== 3'b001) begin n_err++; $display("FAIL flush_flags: got %b want 001", {m16.ready, m16.load_ready, m16.load_busy}); end
      tick;
      n_cmp++; if (m16.ready !== 1'b1) begin n_err++; $display("FAIL flush_one_cycle: got %b want 1", m16.ready); end
      n_cmp++; if (m16.load_words !== 5'd2) begin n_err++; $display("FAIL flush_load_words: got %0d want 2", m16.load_words); end
      model_load16(q);
      rd16(4'd1, d);
      n_cmp++; if (d !== 16'h0033) begin n_err++; $display("FAIL flush_word: got %h want 0033", d); end
   endtask

   task automatic test_full_overflow;
      bq_t q;
      logic [15:0] d;
      for (int i = 0; i < 32; i++) q.push_back(8'($urandom));
      start16;
      foreach (q[i]) byte16(q[i]);
      n_cmp++; if ({m16.ready, m16.load_ready, m16.load_busy} !== 3'b001) begin n_err++; $display("FAIL full_flags: got %b want 001", {m16.ready, m16.load_ready, m16.load_busy}); end
      n_cmp++; if (m16.load_words !== 5'd16) begin n_err++; $display("FAIL full_load_words: got %0d want 16", m16.load_words); end
      n_cmp++; if (m16.load_overflow !== 1'b0) begin n_err++; $display("FAIL full_no_overflow_yet: got %b want 0", m16.load_overflow); end
      byte16(8'hA5);
      n_cmp++; if (m16.load_overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b want 1", m16.load_overflow); end
      end16;
      n_cmp++; if ({m16.ready, m16.load_overflow} !== 2'b11) begin n_err++; $display("FAIL overflow_sticky_idle: got %b want 11", {m16.ready, m16.load_overflow}); end
      model_load16(q);
      for (int i = 0; i < 16; i++) begin
         rd16(4'(i), d);
         n_cmp++; if (d !== mdl16[i]) begin n_err++; $display("FAIL full_mem[%0d]: got %h want %h", i, d, mdl16[i]); end
      end
      start16;
      n_cmp++; if ({m16.load_overflow, m16.load_words} !== 6'd0) begin n_err++; $display("FAIL restart_clears: got ovf=%b words=%0d want 0/0", m16.load_overflow, m16.load_words); end
      end16;
      n_cmp++; if (m16.ready !== 1'b1) begin n_err++; $display("FAIL empty_load_idle: got %b want 1", m16.ready); end
   endtask

   task automatic test_stall;
      logic [15:0] prev, d;
      wr16(4'd3, 16'h1234); mdl16[3] = 16'h1234;
      start16;
      prev = m16.data_out;
      m16.addr = 4'd3; m16.data_in = 16'hBEEF; m16.enable = 1; m16.write_en = 1;
      tick;
      n_cmp++; if ({m16.ready, m16.data_out} !== {1'b0, prev}) begin n_err++; $display("FAIL stall_write: got rdy=%b do=%h want 0/%h", m16.ready, m16.data_out, prev); end
      m16.write_en = 0;
      tick;
      m16.enable = 0;
      n_cmp++; if (m16.data_out !== prev) begin n_err++; $display("FAIL stall_read_holds: got %h want %h", m16.data_out, prev); end
      end16;
      rd16(4'd3, d);
      n_cmp++; if (d !== mdl16[3]) begin n_err++; $display("FAIL stall_mem_unchanged: got %h want %h", d, mdl16[3]); end
      wr16(4'd3, 16'hBEEF); mdl16[3] = 16'hBEEF;
      rd16(4'd3, d);
      n_cmp++; if (d !== 16'hBEEF) begin n_err++; $display("FAIL idle_write: got %h want beef", d); end
   endtask

   task automatic test_edge_coincide;
      bq_t q;
      logic [15:0] d;
      q = '{8'($urandom), 8'($urandom)};
      start16;
      byte16(q[0]);
      m16.load_valid = 1; m16.load_data = q[1]; m16.load_end = 1;
      tick;
      m16.load_valid = 0; m16.load_end = 0;
      n_cmp++; if ({m16.ready, m16.load_words} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL coincide_end: got rdy=%b words=%0d want 1/1", m16.ready, m16.load_words); end
      model_load16(q);
      rd16(4'd0, d);
      n_cmp++; if (d !== mdl16[0]) begin n_err++; $display("FAIL coincide_word: got %h want %h", d, mdl16[0]); end
   endtask

   task automatic test_reset_mid_load;
      bq_t q, q4;
      logic [15:0] d;
      for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
      q4 = q[0:3];
      start16;
      foreach (q[i]) byte16(q[i]);
      reset = 1; tick; reset = 0;
      n_cmp++; if ({m16.ready, m16.load_busy, m16.load_overflow} !== 3'b100) begin n_err++; $display("FAIL midreset_flags: got %b want 100", {m16.ready, m16.load_busy, m16.load_overflow}); end
      n_cmp++; if ({m16.data_out, m16.load_words} !== 21'd0) begin n_err++; $display("FAIL midreset_outputs: got do=%h words=%0d want 0/0", m16.data_out, m16.load_words); end
      model_load16(q4);
      for (int i = 0; i < 3; i++) begin
         rd16(4'(i), d);
         n_cmp++; if (d !== mdl16[i]) begin n_err++; $display("FAIL midreset_mem[%0d]: got %h want %h", i, d, mdl16[i]); end
      end
   endtask

   task automatic test_random_loads;
      bq_t q;
      logic [15:0] d;
      int n, exp_words;
      bit coincide;
      for (int it = 0; it < 8; it++) begin
         q.delete();
         n = $urandom_range(1, 36);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         coincide = (n < 32) && ($urandom_range(0, 1) == 1);
         start16;
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick;
            if (coincide && i == n - 1) begin
               m16.load_valid = 1; m16.load_data = q[i]; m16.load_end = 1;
               tick;
               m16.load_valid = 0; m16.load_end = 0;
            end else begin
               byte16(q[i]);
            end
         end
         if (!coincide) end16;
         for (int c = 0; c < 4 && m16.ready !== 1'b1; c++) tick;
         n_cmp++; if (m16.ready !== 1'b1) begin n_err++; $display("FAIL rand_idle_timeout it%0d: got %b want 1", it, m16.ready); end
         exp_words = (n + 1) / 2 > 16 ? 16 : (n + 1) / 2;
         n_cmp++; if (m16.load_words !== 5'(exp_words)) begin n_err++; $display("FAIL rand_words it%0d n=%0d: got %0d want %0d", it, n, m16.load_words, exp_words); end
         n_cmp++; if (m16.load_overflow !== (n > 32)) begin n_err++; $display("FAIL rand_overflow it%0d n=%0d: got %b want %b", it, n, m16.load_overflow, n > 32); end
         model_load16(q);
         for (int i = 0; i < 16; i++) begin
            rd16(4'(i), d);
            n_cmp++; if (d !== mdl16[i]) begin n_err++; $display("FAIL rand_mem it%0d [%0d]: got %h want %h", it, i, d, mdl16[i]); end
         end
      end
   endtask

   task automatic test_word8;
      logic [7:0] d;
      wr8(4'd0, 8'hFF); wr8(4'd1, 8'hFF);
      m8.load_start = 1; tick; m8.load_start = 0;
      m8.load_valid = 1; m8.load_data = 8'h14; tick;
      m8.load_data = 8'h00; tick;
      m8.load_valid = 0;
      m8.load_end = 1; tick; m8.load_end = 0;
      n_cmp++; if ({m8.ready, m8.load_words} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL w8_no_flush: got rdy=%b words=%0d want 1/2", m8.ready, m8.load_words); end
      rd8(4'd0, d);
      n_cmp++; if (d !== 8'h14) begin n_err++; $display("FAIL w8_mem0: got %h want 14", d); end
      rd8(4'd1, d);
      n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL w8_mem1: got %h want 00", d); end
      rd8(4'd2, d);
      n_cmp++; if (d !== mdl8[2]) begin n_err++; $display("FAIL w8_mem2_untouched: got %h want %h", d, mdl8[2]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs;
      reset = 1;
      test_reset;
      test_cpu_rw;
      test_basic_load;
      test_partial_flush;
      test_full_overflow;
      test_stall;
      test_edge_coincide;
      test_reset_mid_load;
      test_random_loads;
      test_word8;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reflet_prog_mem.md
Name: reflet_prog_mem

Overview:
Parametrised synchronous program memory for simulation and FPGA builds. It replaces fixed hard-coded ROM tables with a RAM of configurable word width and depth. The RAM is filled at run time through a byte-serial loader port with a handshake, then served to the CPU through a single read/write port with 1-cycle read latency. The CPU port is stalled while a load is in progress.

Parameters:
WORD_SIZE, 8, data word width in bits; multiple of 8, range 8..64
ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE words
BYTES (localparam), WORD_SIZE/8, bytes per word

Ports:
clk  in  1  single clock; everything on posedge
reset  in  1  synchronous, active-high
addr  in  ADDR_SIZE  CPU word address
data_in  in  WORD_SIZE  CPU write data
write_en  in  1  CPU write strobe (with enable)
enable  in  1  CPU access request
data_out  out  WORD_SIZE  registered read data
ready  out  1  1 = CPU port serviced (IDLE)
load_start  in  1  pulse: begin load at word 0
load_end  in  1  pulse: terminate load
load_valid  in  1  load_data valid
load_data  in  8  loader byte
load_ready  out  1  loader accepts byte this cycle
load_busy  out  1  1 while not IDLE
load_overflow  out  1  sticky: bytes offered after memory full
load_words  out  ADDR_SIZE+1  words written by current/last load

Behaviour:
- Reset, synchronous and active-high: state IDLE; data_out=0, load_words=0, load_overflow=0, byte index=0, assembly register=0. Memory array is not cleared. Reset mid-load aborts the load; words already written are retained.
- FSM states: IDLE, LOAD, FLUSH, FULL.
- IDLE: ready=1, load_ready=0, load_busy=0.
  - enable & write_en: mem[addr]<=data_in; data_out holds.
  - enable & !write_en: data_out<=mem[addr] at next posedge (latency 1).
  - enable=0: data_out holds.
  - load_start: next state LOAD; ptr=0, byte idx=0, load_words=0, load_overflow=0. A CPU access in the same cycle is still performed.
- LOAD: ready=0, load_ready=1, load_busy=1; CPU writes ignored, data_out holds.
  - Each load_valid byte goes into assembly lane idx (little-endian: first byte is bits [7:0]); idx++.
  - When idx==BYTES-1, the full word is written to mem[ptr] that edge; ptr++, load_words++, idx=0.
  - If that write is to word 2**ADDR_SIZE-1, next state is FULL.
- load_end in LOAD:
  - If load_valid is high in the same cycle, the byte is accepted first.
  - If idx (after accept) is 0, go to IDLE.
  - Otherwise go to FLUSH.
- FLUSH (1 cycle): write the partial word zero-padded in the upper lanes to mem[ptr]; load_words++; go to IDLE. load_ready=0.
- FULL: load_ready=0; load_valid sets load_overflow (sticky until next load_start or reset); bytes are dropped. load_end goes to IDLE.
- load_start outside IDLE is ignored. load_end outside LOAD/FULL is ignored.
- Throughput: one byte per cycle; no bubbles at word boundaries.
- load_words saturates at 2**ADDR_SIZE; ptr never wraps.

Decomposition:
- Shared package: FSM state encoding (IDLE/LOAD/FLUSH/FULL) and the WORD_SIZE legality check constant; reused by other Reflet memory blocks.
- One sub-module, reflet_byte_packer: byte-to-word assembly (idx counter, lane insert, word_valid, partial flush with zero pad).
- Top level owns the FSM, the memory array and the CPU port.

Test Plan:
Use WORD_SIZE=16, ADDR_SIZE=4 unless noted.
- Basic load: load_start; bytes 0x41,0x53,0x52,0x4D back-to-back; load_end -> mem[0]=0x5341, mem[1]=0x4D52; load_words=2; IDLE 1 cycle after load_end; read addr 1 -> data_out=0x4D52 exactly one cycle after enable.
- Partial flush: load 3 bytes 0x11,0x22,0x33, then load_end -> FLUSH 1 cycle; mem[1]=0x0033; load_words=2.
- Full/overflow: stream 33 bytes -> after byte 32 state FULL, load_ready=0, load_words=16; 33rd byte sets load_overflow=1 and memory is unchanged; load_end -> IDLE; next load_start clears load_overflow.
- Stall: issue an enable&write_en to addr 3 with 0xBEEF during LOAD -> ready=0, mem[3] unchanged, data_out unchanged; same write in IDLE -> mem[3]=0xBEEF.
- Edge coincidences: load_valid+load_end on a word-completing byte -> word written, direct to IDLE with no FLUSH; reset asserted mid-load after 5 bytes -> IDLE, outputs 0, mem[0..1] retained.
- WORD_SIZE=8: each byte is a word; load 0x14,0x00 -> mem[0]=0x14, mem[1]=0x00, FLUSH never entered.
